vc_arbiter: RTL and testbench
=============================

// Module: vc_arbiter
// PURPOSE
//  Round-robin arbiter that drains the four virtual-channel FIFOs into the two destination FIFOs.
//  Sits downstream of the VC FIFOs and is gated by the control FSM's active_out.
//  Skips any VC whose head word targets an almost-full destination, so one blocked VC never stalls the others.
//  Keeps a per-destination word count for the debug and test logic.
// PARAMETERS
//  DATA_W    6   width of one data word
//  NUM_VC    4   number of VC FIFOs (fixed at 4 for pointer width 2)
//  DEST_BIT  4   bit of the head word that selects the destination (0 -> D0, 1 -> D1)
// PORTS
//  clk             in   1          single clock, rising edge
//  reset           in   1          asynchronous, active-low; clears all state immediately
//  enable          in   1          run permission, driven from the FSM active_out
//  vc_empty        in   4          empty flag of each VC FIFO
//  vc_data         in   4*DATA_W   head word of each VC FIFO (first-word-fall-through); VCi at [i*DATA_W +: DATA_W]
//  dest_afull      in   2          almost-full flag of D0/D1
//  vc_pop          out  4          one-hot pop of the granted VC, combinational, same cycle as the grant
//  dest_push       out  2          one-hot push to D0/D1, registered
//  dest_data       out  DATA_W     word that goes with dest_push, registered
//  grant_vc        out  2          index of the last granted VC, registered
//  idle            out  1          high in RUN when no push is pending and every VC is empty
//  cnt_d0, cnt_d1  out  8          words pushed to each destination, wrap 255 -> 0
// BEHAVIOUR
//  Reset values
//  - On reset low: vc_pop=0, dest_push=0, dest_data=0, grant_vc=0, cnt_*=0, rr_ptr=0, state=OFF.
//  - idle is 0 while state=OFF.
//  Eligibility
//  - VCi is eligible when: state=RUN, enable=1, !vc_empty[i], and !dest_afull[vc_data[i][DEST_BIT]].
//  Grant rule (cycle N)
//  - Search the eligible VCs starting at rr_ptr, ascending, wrapping 3 -> 0.
//  - The first hit i is granted: vc_pop[i]=1 in cycle N.
//  - At the edge ending cycle N: rr_ptr<=i+1 (mod 4), grant_vc<=i, dest_data<=vc_data[i], dest_push<=one-hot(dest).
//  - No eligible VC: vc_pop=0, and at the next edge dest_push<=0 and rr_ptr holds.
//  - Throughput is at most one word per cycle. Pop-to-push latency is exactly 1 cycle.
//  Flow control
//  - dest_afull is sampled in the grant cycle, so one word can be in flight after dest_afull rises.
//  - The destination FIFO thresholds must leave at least 1 free slot beyond the almost-full level.
//  - Each counter increments on the clock edge after its dest_push is high.
//  FSM states
//  - OFF  -> RUN  when enable=1.
//  - RUN  -> OFF  when enable=0. vc_pop is 0 in the cycle enable is low.
//  - An already-registered push still completes on the next edge; no word is dropped or duplicated.
//  - OFF keeps rr_ptr and the counters. Only reset clears them.
//  Boundary cases
//  - All VCs empty: no pop, idle=1 once the pending push has retired.
//  - Both destinations almost full: no pop, even if VCs hold data.
//  - vc_empty[i] and dest_afull changing in the same cycle: only the current-cycle values are used (combinational).
//  - Reset asserted mid-transfer: the pending push is cancelled at once. Any word already popped is lost; this is accepted.
// STRUCTURE
//  - Shared package/include: state encodings (OFF=1'b0, RUN=1'b1), NUM_VC, DATA_W, DEST_BIT.
//  - One sub-module, rr_pick4: combinational. Inputs are a 4-bit eligible mask and a 2-bit pointer; outputs are a valid flag and a 2-bit index.
//  - The top level holds the FSM, output registers, rr_ptr and counters.
// TESTING (DATA_W=6, DEST_BIT=4)
//  1. Reset low mid-run with dest_push=1.
//     -> All outputs are 0 in the same cycle, with no clock edge needed. After reset high, state=OFF.
//  2. enable=1; VC0..VC3 each hold one word 6'h01, 6'h12, 6'h03, 6'h14.
//     -> Pops on VC0, 1, 2, 3 in consecutive cycles.
//     -> Pushes one cycle later: D0, D1, D0, D1 with those words.
//     -> Final cnt_d0=2, cnt_d1=2, then idle=1.
//  3. Every VC always non-empty, dest_afull=0.
//     -> Grants rotate 0, 1, 2, 3, 0 ...; no VC is granted twice within any 4 grants.
//  4. dest_afull=2'b10; VC1 head=6'h10 (D1), VC2 head=6'h02 (D0).
//     -> VC1 is never popped, VC2 is popped.
//     -> After dest_afull drops to 0, VC1 is popped on the next grant.
//  5. enable drops in the cycle after a grant.
//     -> The pending push completes, no further pops occur, state=OFF.
//     -> After re-enable, arbitration resumes from the saved rr_ptr.
//  6. Push 256 words to D0.
//     -> cnt_d0 wraps to 0; cnt_d1 is unchanged.

Source files
------------

// File: rtl/vc_arbiter_pkg.sv
// Shared constants and types for the VC arbiter.
// State encoding, word geometry and destination decode.
package vc_arbiter_pkg;

    localparam int DATA_W   = 6;
    localparam int NUM_VC   = 4;
    localparam int DEST_BIT = 4;

    typedef enum logic {
        OFF = 1'b0,
        RUN = 1'b1
    } state_t;

    // Destination select bit to one-hot push (bit 0 = D0, bit 1 = D1).
    function automatic logic [1:0] dest_onehot(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick over four requesters.
// Returns the first set mask bit at or after ptr, wrapping 3 -> 0.
module rr_pick4
    import vc_arbiter_pkg::*;
(
    input  logic [NUM_VC-1:0] eligible,
    input  logic [1:0]        ptr,
    output logic              valid,
    output logic [1:0]        idx
);

    logic [1:0] cand;

    // Walk the offsets from far to near so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (eligible[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/vc_arbiter.sv
// Round-robin drain of four VC FIFOs into two destination FIFOs.
// VCs whose head targets an almost-full destination are skipped.
module vc_arbiter
    import vc_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_VC-1:0]        vc_empty,
    input  logic [NUM_VC*DATA_W-1:0] vc_data,
    input  logic [1:0]               dest_afull,
    output logic [NUM_VC-1:0]        vc_pop,
    output logic [1:0]               dest_push,
    output logic [DATA_W-1:0]        dest_data,
    output logic [1:0]               grant_vc,
    output logic                     idle,
    output logic [7:0]               cnt_d0,
    output logic [7:0]               cnt_d1
);

    state_t            state;
    state_t            state_nx;
    logic [1:0]        rr_ptr;
    logic [NUM_VC-1:0] eligible;
    logic              pick_valid;
    logic [1:0]        pick_idx;
    logic [DATA_W-1:0] pick_word;

    // Run/stop control follows the enable level.
    always_comb begin
        state_nx = state;
        unique case (state)
            OFF:     if (enable)  state_nx = RUN;
            RUN:     if (!enable) state_nx = OFF;
            default: state_nx = OFF;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= OFF;
        else        state <= state_nx;
    end

    // A VC may go when it has data and its target has room.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            eligible[i] = (state == RUN) && enable && !vc_empty[i]
                && !dest_afull[vc_data[i*DATA_W + DEST_BIT]];
        end
    end

    rr_pick4 u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    assign pick_word = vc_data[32'(pick_idx)*DATA_W +: DATA_W];

    // Pop the granted VC in the grant cycle itself.
    always_comb begin
        vc_pop = '0;
        if (pick_valid) vc_pop[pick_idx] = 1'b1;
    end

    // Register the granted word one cycle behind the pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dest_push <= 2'b00;
            dest_data <= '0;
            grant_vc  <= 2'd0;
            rr_ptr    <= 2'd0;
        end else if (pick_valid) begin
            dest_push <= dest_onehot(pick_word[DEST_BIT]);
            dest_data <= pick_word;
            grant_vc  <= pick_idx;
            rr_ptr    <= pick_idx + 2'd1;
        end else begin
            dest_push <= 2'b00;
        end
    end

    // Count words as their push retires; counters wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_d0 <= 8'd0;
            cnt_d1 <= 8'd0;
        end else begin
            if (dest_push[0]) cnt_d0 <= cnt_d0 + 8'd1;
            if (dest_push[1]) cnt_d1 <= cnt_d1 + 8'd1;
        end
    end

    assign idle = (state == RUN) && (dest_push == 2'b00) && (&vc_empty);

endmodule

// File: tb/tb_vc_arbiter.sv
// Self-checking bench for vc_arbiter.
// Table vectors, directed corner sequences and random traffic vs a model.
module tb_vc_arbiter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  vc_empty;
    logic [23:0] vc_data;
    logic [1:0]  dest_afull;
    logic [3:0]  vc_pop;
    logic [1:0]  dest_push;
    logic [5:0]  dest_data;
    logic [1:0]  grant_vc;
    logic        idle;
    logic [7:0]  cnt_d0;
    logic [7:0]  cnt_d1;

    vc_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .vc_empty   (vc_empty),
        .vc_data    (vc_data),
        .dest_afull (dest_afull),
        .vc_pop     (vc_pop),
        .dest_push  (dest_push),
        .dest_data  (dest_data),
        .grant_vc   (grant_vc),
        .idle       (idle),
        .cnt_d0     (cnt_d0),
        .cnt_d1     (cnt_d1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [23:0] D2 = {6'h14, 6'h03, 6'h12, 6'h01};

    int tests;
    int fails;

    // Reference model state (plain integers).
    bit m_run;
    int m_ptr;
    int m_push;
    int m_data;
    int m_gv;
    int m_c0;
    int m_c1;

    // Outputs sampled at the falling edge of the last cycle.
    logic [3:0] s_pop;
    logic [1:0] s_push;
    logic [5:0] s_data;
    logic       s_idle;
    logic [7:0] s_c0;
    logic [7:0] s_c1;

    typedef struct {
        logic       en;
        logic [3:0] emp;
        logic [3:0] pop;
        logic [1:0] push;
        logic [5:0] data;
        logic       idl;
        logic [7:0] c0;
        logic [7:0] c1;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int word_of(input logic [23:0] dat, input int v);
        return int'((dat >> (v * 6)) & 24'h3f);
    endfunction

    function automatic int oh2i(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh == (4'b1 << i)) return i;
        return -1;
    endfunction

    // Which VC the rules grant this cycle, or -1.
    function automatic int model_pick(input logic en, input logic [3:0] emp,
                                      input logic [23:0] dat, input logic [1:0] af);
        if (!m_run || !en) return -1;
        for (int k = 0; k < 4; k++) begin
            int v;
            int d;
            v = (m_ptr + k) % 4;
            d = (word_of(dat, v) / 16) % 2;
            if (!emp[v] && !af[d]) return v;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_run  = 0;
        m_ptr  = 0;
        m_push = 0;
        m_data = 0;
        m_gv   = 0;
        m_c0   = 0;
        m_c1   = 0;
    endfunction

    // One clock cycle: drive, check at negedge, advance model, reach posedge+1.
    task automatic cycle(input logic en, input logic [3:0] emp,
                         input logic [23:0] dat, input logic [1:0] af);
        int g;
        int w;
        enable     = en;
        vc_empty   = emp;
        vc_data    = dat;
        dest_afull = af;
        @(negedge clk);
        g = model_pick(en, emp, dat, af);
        s_pop  = vc_pop;
        s_push = dest_push;
        s_data = dest_data;
        s_idle = idle;
        s_c0   = cnt_d0;
        s_c1   = cnt_d1;
        chk("vc_pop", int'(vc_pop), (g < 0) ? 0 : (1 << g));
        chk("dest_push", int'(dest_push), m_push);
        chk("dest_data", int'(dest_data), m_data);
        chk("grant_vc", int'(grant_vc), m_gv);
        chk("idle", int'(idle), (m_run && m_push == 0 && emp == 4'hf) ? 1 : 0);
        chk("cnt_d0", int'(cnt_d0), m_c0);
        chk("cnt_d1", int'(cnt_d1), m_c1);
        if (m_push == 1) m_c0 = (m_c0 + 1) % 256;
        if (m_push == 2) m_c1 = (m_c1 + 1) % 256;
        if (g >= 0) begin
            w      = word_of(dat, g);
            m_ptr  = (g + 1) % 4;
            m_gv   = g;
            m_data = w;
            m_push = ((w / 16) % 2 == 1) ? 2 : 1;
        end else begin
            m_push = 0;
        end
        m_run = en;
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle; everything must clear with no edge.
    task automatic reset_mid();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_vc_pop", int'(vc_pop), 0);
        chk("rst_dest_push", int'(dest_push), 0);
        chk("rst_dest_data", int'(dest_data), 0);
        chk("rst_grant_vc", int'(grant_vc), 0);
        chk("rst_idle", int'(idle), 0);
        chk("rst_cnt_d0", int'(cnt_d0), 0);
        chk("rst_cnt_d1", int'(cnt_d1), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int g;
        int prev;
        int w;
        bit seen255;

        tests = 0;
        fails = 0;
        reset = 1'b0;
        enable = 1'b0;
        vc_empty = 4'hf;
        vc_data = '0;
        dest_afull = 2'b00;
        model_reset();

        tbl[0] = '{1'b1, 4'b0000, 4'b0000, 2'b00, 6'h00, 1'b0, 8'd0, 8'd0};
        tbl[1] = '{1'b1, 4'b0000, 4'b0001, 2'b00, 6'h00, 1'b0, 8'd0, 8'd0};
        tbl[2] = '{1'b1, 4'b0001, 4'b0010, 2'b01, 6'h01, 1'b0, 8'd0, 8'd0};
        tbl[3] = '{1'b1, 4'b0011, 4'b0100, 2'b10, 6'h12, 1'b0, 8'd1, 8'd0};
        tbl[4] = '{1'b1, 4'b0111, 4'b1000, 2'b01, 6'h03, 1'b0, 8'd1, 8'd1};
        tbl[5] = '{1'b1, 4'b1111, 4'b0000, 2'b10, 6'h14, 1'b0, 8'd2, 8'd1};
        tbl[6] = '{1'b1, 4'b1111, 4'b0000, 2'b00, 6'h14, 1'b1, 8'd2, 8'd2};

        // Power-on reset values.
        #12;
        chk("por_vc_pop", int'(vc_pop), 0);
        chk("por_dest_push", int'(dest_push), 0);
        chk("por_idle", int'(idle), 0);
        chk("por_cnt_d0", int'(cnt_d0), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset mid-run while a push is pending.
        cycle(1'b1, 4'h0, D2, 2'b00);
        cycle(1'b1, 4'h0, D2, 2'b00);
        cycle(1'b1, 4'h0, D2, 2'b00);
        chk("pre_rst_push", int'(dest_push), 2);
        reset_mid();

        // Four single-word VCs drained in order.
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].en, tbl[i].emp, D2, 2'b00);
            chk($sformatf("tbl%0d_pop", i), int'(s_pop), int'(tbl[i].pop));
            chk($sformatf("tbl%0d_push", i), int'(s_push), int'(tbl[i].push));
            chk($sformatf("tbl%0d_data", i), int'(s_data), int'(tbl[i].data));
            chk($sformatf("tbl%0d_idle", i), int'(s_idle), int'(tbl[i].idl));
            chk($sformatf("tbl%0d_c0", i), int'(s_c0), int'(tbl[i].c0));
            chk($sformatf("tbl%0d_c1", i), int'(s_c1), int'(tbl[i].c1));
        end

        // All VCs busy: strict rotation.
        prev = -1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 4'h0, 24'($urandom), 2'b00);
            g = oh2i(s_pop);
            if (prev >= 0) chk("rotate", g, (prev + 1) % 4);
            prev = g;
        end

        // D1 almost full: VC1 blocked, VC2 keeps flowing.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 4'b1001, {6'h00, 6'h02, 6'h10, 6'h00}, 2'b10);
            chk("afull_pop", int'(s_pop), 4'b0100);
        end
        cycle(1'b1, 4'b1001, {6'h00, 6'h02, 6'h10, 6'h00}, 2'b00);
        chk("afull_release", int'(s_pop), 4'b0010);

        // Both destinations almost full: nothing moves.
        cycle(1'b1, 4'h0, D2, 2'b11);
        chk("both_afull", int'(s_pop), 0);

        // Enable drops after a grant; resume from saved pointer.
        cycle(1'b1, 4'h0, D2, 2'b00);
        g = oh2i(s_pop);
        w = word_of(D2, g);
        cycle(1'b0, 4'h0, D2, 2'b00);
        chk("stop_pop", int'(s_pop), 0);
        chk("stop_push", int'(s_push), ((w / 16) % 2 == 1) ? 2 : 1);
        cycle(1'b0, 4'hf, D2, 2'b00);
        chk("off_push", int'(s_push), 0);
        chk("off_idle", int'(s_idle), 0);
        cycle(1'b1, 4'h0, D2, 2'b00);
        chk("wake_pop", int'(s_pop), 0);
        cycle(1'b1, 4'h0, D2, 2'b00);
        chk("resume", oh2i(s_pop), (g + 1) % 4);

        // 256 words to D0: counter wraps, D1 untouched.
        reset_mid();
        seen255 = 0;
        cycle(1'b1, 4'hf, D2, 2'b00);
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 4'b1110, D2, 2'b00);
            if (s_c0 == 8'd255) seen255 = 1;
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 4'hf, D2, 2'b00);
            if (s_c0 == 8'd255) seen255 = 1;
        end
        chk("wrap_seen255", int'(seen255), 1);
        chk("wrap_cnt_d0", int'(s_c0), 0);
        chk("wrap_cnt_d1", int'(s_c1), 0);
        chk("wrap_idle", int'(s_idle), 1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                  4'($urandom),
                  24'($urandom),
                  ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
